// File: rtl/axil_mmio_slot_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axil_mmio_slot_bridge_if                                                   |
// | AXI4-Lite bus bundle between the main-bus interconnect and the slot bridge |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface axil_mmio_slot_bridge_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axil_mmio_slot_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axil_mmio_slot_bridge                                                      |
// | AXI4-Lite slave fanning out to NUM_SLOTS MMIO devices with round-robin     |
// | read/write arbitration. Optional access watchdog: MMIO_TIMEOUT_EN.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module axil_mmio_slot_bridge #(
  parameter int          NUM_SLOTS      = 16,
  parameter int          REG_AW         = 8,
  parameter logic [15:0] BASE_HI        = 16'h4600,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                      aclk,
  input  logic                      arst_n,
  axil_mmio_slot_bridge_if.slave    S_AXI,
  output logic [NUM_SLOTS-1:0]      slot_cs,
  output logic                      slot_read,
  output logic                      slot_write,
  output logic [REG_AW-1:0]         slot_reg_addr,
  output logic [31:0]               slot_wr_data,
  output logic [3:0]                slot_wstrb,
  input  logic [NUM_SLOTS*32-1:0]   slot_rd_data,
  input  logic [NUM_SLOTS-1:0]      slot_wr_done,
  input  logic [NUM_SLOTS-1:0]      slot_rd_done,
  input  logic [NUM_SLOTS-1:0]      slot_slave_error,
  input  logic [NUM_SLOTS-1:0]      slot_decode_error
);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_ACCESS = 3'd1,
    ST_WR_RESP   = 3'd2,
    ST_RD_ACCESS = 3'd3,
    ST_RD_RESP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  aw_cap_q, aw_cap_d;
  logic                  w_cap_q, w_cap_d;
  logic                  ar_pend_q, ar_pend_d;
  logic                  rr_pri_q, rr_pri_d;
  logic [31:0]           awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           araddr_q, araddr_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  arready_q, arready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [NUM_SLOTS-1:0]  slot_cs_q, slot_cs_d;
  logic                  slot_read_q, slot_read_d;
  logic                  slot_write_q, slot_write_d;
  logic [REG_AW-1:0]     slot_reg_addr_q, slot_reg_addr_d;
  logic [31:0]           slot_wr_data_q, slot_wr_data_d;
  logic [3:0]            slot_wstrb_q, slot_wstrb_d;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_elig, rd_elig, grant_wr, grant_rd;
  logic [31:0] cur_awaddr, cur_wdata, cur_araddr;
  logic [3:0]  cur_wstrb;
  logic        sel_wr_done, sel_rd_done;
  logic [1:0]  sel_resp;
  logic [31:0] sel_rd_data;

  function automatic logic dec_hit(input logic [31:0] a);
    return (a[31:16] == BASE_HI) && ({1'b0, a[15:8]} < 9'(NUM_SLOTS));
  endfunction

  assign aw_hs = S_AXI.awvalid && awready_q;
  assign w_hs  = S_AXI.wvalid  && wready_q;
  assign ar_hs = S_AXI.arvalid && arready_q;

  // Same-cycle handshakes count, so AW/W/AR arriving together are arbitrated at once.
  assign cur_awaddr = aw_cap_q  ? awaddr_q : S_AXI.awaddr;
  assign cur_wdata  = w_cap_q   ? wdata_q  : S_AXI.wdata;
  assign cur_wstrb  = w_cap_q   ? wstrb_q  : S_AXI.wstrb;
  assign cur_araddr = ar_pend_q ? araddr_q : S_AXI.araddr;

  assign wr_elig  = (aw_cap_q || aw_hs) && (w_cap_q || w_hs);
  assign rd_elig  = ar_pend_q || ar_hs;
  assign grant_wr = (state_q == ST_IDLE) && wr_elig && (!rd_elig || !rr_pri_q);
  assign grant_rd = (state_q == ST_IDLE) && rd_elig && !grant_wr;

  // Masking with the registered chip select discards strays from other slots.
  assign sel_wr_done = |(slot_wr_done & slot_cs_q);
  assign sel_rd_done = |(slot_rd_done & slot_cs_q);
  assign sel_resp    = |(slot_slave_error & slot_cs_q)  ? c_RESP_SLVERR :
                       |(slot_decode_error & slot_cs_q) ? c_RESP_DECERR : c_RESP_OKAY;

  always_comb begin
    sel_rd_data = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_cs_q[i]) sel_rd_data = sel_rd_data | slot_rd_data[32*i +: 32];
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [c_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic               tmo_expired;
  assign tmo_expired = (tmo_cnt_q == c_TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d         = state_q;
    aw_cap_d        = aw_cap_q;
    w_cap_d         = w_cap_q;
    ar_pend_d       = ar_pend_q;
    rr_pri_d        = rr_pri_q;
    awaddr_d        = awaddr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    araddr_d        = araddr_q;
    bvalid_d        = bvalid_q;
    bresp_d         = bresp_q;
    rvalid_d        = rvalid_q;
    rresp_d         = rresp_q;
    rdata_d         = rdata_q;
    slot_cs_d       = slot_cs_q;
    slot_read_d     = slot_read_q;
    slot_write_d    = slot_write_q;
    slot_reg_addr_d = slot_reg_addr_q;
    slot_wr_data_d  = slot_wr_data_q;
    slot_wstrb_d    = slot_wstrb_q;
`ifdef MMIO_TIMEOUT_EN
    tmo_cnt_d       = tmo_cnt_q;
`endif

    if (aw_hs) begin
      aw_cap_d = 1'b1;
      awaddr_d = S_AXI.awaddr;
    end
    if (w_hs) begin
      w_cap_d = 1'b1;
      wdata_d = S_AXI.wdata;
      wstrb_d = S_AXI.wstrb;
    end
    if (ar_hs) araddr_d = S_AXI.araddr;

    case (state_q)
      ST_IDLE: begin
`ifdef MMIO_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        // An AR accepted alongside a winning write is parked until the write retires.
        if (ar_hs && !grant_rd) ar_pend_d = 1'b1;
        if (grant_wr) begin
          rr_pri_d = !rr_pri_q;
          if (dec_hit(cur_awaddr)) begin
            state_d         = ST_WR_ACCESS;
            slot_cs_d       = NUM_SLOTS'(1) << cur_awaddr[15:8];
            slot_write_d    = 1'b1;
            slot_reg_addr_d = cur_awaddr[REG_AW-1:0];
            slot_wr_data_d  = cur_wdata;
            slot_wstrb_d    = cur_wstrb;
          end else begin
            state_d  = ST_WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = c_RESP_DECERR;
          end
        end else if (grant_rd) begin
          rr_pri_d  = !rr_pri_q;
          ar_pend_d = 1'b0;
          if (dec_hit(cur_araddr)) begin
            state_d         = ST_RD_ACCESS;
            slot_cs_d       = NUM_SLOTS'(1) << cur_araddr[15:8];
            slot_read_d     = 1'b1;
            slot_reg_addr_d = cur_araddr[REG_AW-1:0];
          end else begin
            state_d  = ST_RD_RESP;
            rvalid_d = 1'b1;
            rresp_d  = c_RESP_DECERR;
            rdata_d  = '0;
          end
        end
      end
      ST_WR_ACCESS: begin
        if (sel_wr_done) begin
          state_d      = ST_WR_RESP;
          slot_cs_d    = '0;
          slot_write_d = 1'b0;
          bvalid_d     = 1'b1;
          bresp_d      = sel_resp;
        end
`ifdef MMIO_TIMEOUT_EN
        else if (tmo_expired) begin
          state_d      = ST_WR_RESP;
          slot_cs_d    = '0;
          slot_write_d = 1'b0;
          bvalid_d     = 1'b1;
          bresp_d      = c_RESP_SLVERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      ST_WR_RESP: begin
        if (S_AXI.bready) begin
          state_d  = ST_IDLE;
          bvalid_d = 1'b0;
          aw_cap_d = 1'b0;
          w_cap_d  = 1'b0;
        end
      end
      ST_RD_ACCESS: begin
        if (sel_rd_done) begin
          state_d     = ST_RD_RESP;
          slot_cs_d   = '0;
          slot_read_d = 1'b0;
          rvalid_d    = 1'b1;
          rresp_d     = sel_resp;
          rdata_d     = sel_rd_data;
        end
`ifdef MMIO_TIMEOUT_EN
        else if (tmo_expired) begin
          state_d     = ST_RD_RESP;
          slot_cs_d   = '0;
          slot_read_d = 1'b0;
          rvalid_d    = 1'b1;
          rresp_d     = c_RESP_SLVERR;
          rdata_d     = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      ST_RD_RESP: begin
        if (S_AXI.rready) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    awready_d = (state_d == ST_IDLE) && !aw_cap_d;
    wready_d  = (state_d == ST_IDLE) && !w_cap_d;
    arready_d = (state_d == ST_IDLE) && !aw_cap_d && !w_cap_d && !ar_pend_d;
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q         <= ST_IDLE;
      aw_cap_q        <= 1'b0;
      w_cap_q         <= 1'b0;
      ar_pend_q       <= 1'b0;
      rr_pri_q        <= 1'b0;
      awaddr_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      araddr_q        <= '0;
      awready_q       <= 1'b0;
      wready_q        <= 1'b0;
      arready_q       <= 1'b0;
      bvalid_q        <= 1'b0;
      bresp_q         <= '0;
      rvalid_q        <= 1'b0;
      rresp_q         <= '0;
      rdata_q         <= '0;
      slot_cs_q       <= '0;
      slot_read_q     <= 1'b0;
      slot_write_q    <= 1'b0;
      slot_reg_addr_q <= '0;
      slot_wr_data_q  <= '0;
      slot_wstrb_q    <= '0;
`ifdef MMIO_TIMEOUT_EN
      tmo_cnt_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      aw_cap_q        <= aw_cap_d;
      w_cap_q         <= w_cap_d;
      ar_pend_q       <= ar_pend_d;
      rr_pri_q        <= rr_pri_d;
      awaddr_q        <= awaddr_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      araddr_q        <= araddr_d;
      awready_q       <= awready_d;
      wready_q        <= wready_d;
      arready_q       <= arready_d;
      bvalid_q        <= bvalid_d;
      bresp_q         <= bresp_d;
      rvalid_q        <= rvalid_d;
      rresp_q         <= rresp_d;
      rdata_q         <= rdata_d;
      slot_cs_q       <= slot_cs_d;
      slot_read_q     <= slot_read_d;
      slot_write_q    <= slot_write_d;
      slot_reg_addr_q <= slot_reg_addr_d;
      slot_wr_data_q  <= slot_wr_data_d;
      slot_wstrb_q    <= slot_wstrb_d;
`ifdef MMIO_TIMEOUT_EN
      tmo_cnt_q       <= tmo_cnt_d;
`endif
    end
  end

  assign S_AXI.awready = awready_q;
  assign S_AXI.wready  = wready_q;
  assign S_AXI.arready = arready_q;
  assign S_AXI.bvalid  = bvalid_q;
  assign S_AXI.bresp   = bresp_q;
  assign S_AXI.rvalid  = rvalid_q;
  assign S_AXI.rresp   = rresp_q;
  assign S_AXI.rdata   = rdata_q;
  assign slot_cs       = slot_cs_q;
  assign slot_read     = slot_read_q;
  assign slot_write    = slot_write_q;
  assign slot_reg_addr = slot_reg_addr_q;
  assign slot_wr_data  = slot_wr_data_q;
  assign slot_wstrb    = slot_wstrb_q;

  // Protection bits and the address bits between the register and slot fields carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI.awprot, S_AXI.arprot, cur_awaddr, cur_araddr, 32'(TIMEOUT_CYCLES)};

endmodule
`default_nettype wire
